// File: rtl/schoolbook_pkg.sv
// Shared types and elaboration helpers for the digit-serial schoolbook multiplier.
// Both helpers are evaluated at elaboration time to size the top level.
package schoolbook_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int ndig(input int bw, input int dw);
        return (dw < 1) ? 1 : (bw + dw - 1) / dw;
    endfunction

    function automatic int cntw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/schoolbook_digit_mac.sv
// Combinational digit multiply-accumulate: sum = acc_in + ((a * d) << shift).
// The partial product is AW+DW bits wide and is widened to OW before shifting.
module schoolbook_digit_mac #(
    parameter int AW = 409,
    parameter int DW = 8,
    parameter int OW = 818
) (
    input  logic [OW-1:0]         acc_in,
    input  logic [AW-1:0]         a,
    input  logic [DW-1:0]         d,
    input  logic [$clog2(OW):0]   shift,
    output logic [OW-1:0]         sum
);

    logic [AW+DW-1:0] pp;

    assign pp  = {{DW{1'b0}}, a} * {{AW{1'b0}}, d};
    assign sum = acc_in + (OW'(pp) << shift);

endmodule

// File: rtl/schoolbook_seq.sv
// Digit-serial schoolbook multiplier c = a * b, DW bits of b per cycle,
// with a start/ready/done handshake for back-to-back reuse.
module schoolbook_seq
    import schoolbook_pkg::*;
#(
    parameter int AW = 409,
    parameter int BW = 409,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     a,
    input  logic [BW-1:0]     b,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [AW+BW-1:0]  c
);

    localparam int NDIG = ndig(BW, DW);
    localparam int KW   = cntw(NDIG);
    localparam int BPW  = NDIG * DW;
    localparam int OW   = AW + BW;
    localparam int SHW  = $clog2(OW) + 1;

    if (DW < 1 || DW > BW) begin : g_bad_dw
        $fatal(1, "schoolbook_seq: DW must satisfy 1 <= DW <= BW");
    end

    state_t          state;
    logic [KW-1:0]   k;
    logic [AW-1:0]   a_r;
    logic [BPW-1:0]  b_r;
    logic [OW-1:0]   acc;
    logic [OW-1:0]   sum;
    logic [SHW-1:0]  shift;
    logic            last;

    assign shift = SHW'(k) * SHW'(DW);
    assign last  = (k == KW'(NDIG - 1));
    assign ready = (state == IDLE) && !rst;
    assign busy  = (state == RUN);

    // b_r shifts down one digit per cycle, so the live digit is always at the bottom
    schoolbook_digit_mac #(
        .AW (AW),
        .DW (DW),
        .OW (OW)
    ) u_mac (
        .acc_in (acc),
        .a      (a_r),
        .d      (b_r[DW-1:0]),
        .shift  (shift),
        .sum    (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            c     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= BPW'(b);
                        acc   <= '0;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= sum;
                    b_r <= b_r >> DW;
                    if (last) begin
                        c     <= sum;
                        done  <= 1'b1;
                        k     <= '0;
                        state <= IDLE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_schoolbook_seq.sv
// Directed bench for schoolbook_seq across four parameter sets.
// Expected products are hand-derived constants or a*b computed in the bench.
module tb_schoolbook_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   st  = '0;
    logic [408:0] av  = '0;
    logic [408:0] bv  = '0;

    logic [3:0]   rdy, bsy, dn;
    logic [817:0] c0;
    logic [31:0]  c1;
    logic [13:0]  c2;
    logic [15:0]  c3;

    int sel = 0;
    int nvec = 0;
    int nerr = 0;

    logic          ready_m, busy_m, done_m;
    logic [1023:0] c_m;

    always #5 clk = ~clk;

    schoolbook_seq u0 (
        .clk(clk), .rst(rst), .start(st[0]), .a(av), .b(bv),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .c(c0)
    );

    schoolbook_seq #(.AW(16), .BW(16), .DW(4)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .a(av[15:0]), .b(bv[15:0]),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .c(c1)
    );

    schoolbook_seq #(.AW(4), .BW(10), .DW(4)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .a(av[3:0]), .b(bv[9:0]),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .c(c2)
    );

    schoolbook_seq #(.AW(8), .BW(8), .DW(1)) u3 (
        .clk(clk), .rst(rst), .start(st[3]), .a(av[7:0]), .b(bv[7:0]),
        .ready(rdy[3]), .busy(bsy[3]), .done(dn[3]), .c(c3)
    );

    always_comb begin
        ready_m = rdy[sel];
        busy_m  = bsy[sel];
        done_m  = dn[sel];
        c_m     = '0;
        case (sel)
            0:       c_m = 1024'(c0);
            1:       c_m = 1024'(c1);
            2:       c_m = 1024'(c2);
            default: c_m = 1024'(c3);
        endcase
    end

    task automatic chk(input string tag, input logic [1023:0] obs,
                       input logic [1023:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int s, input logic [408:0] x,
                       input logic [408:0] y, input logic [1023:0] e,
                       input int lat, input string tag);
        int n;
        int nb;
        logic [1023:0] old;
        logic stable;
        sel = s;
        @(negedge clk);
        av = x;
        bv = y;
        st[s] = 1'b1;
        @(posedge clk);
        #1;
        st[s] = 1'b0;
        chk({tag, " busy"}, 1024'(busy_m), 1024'(1));
        chk({tag, " ready lo"}, 1024'(ready_m), 1024'(0));
        old = c_m;
        stable = 1'b1;
        n = 0;
        nb = 1;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy_m) nb++;
            if (!done_m && c_m !== old) stable = 1'b0;
        end while (!done_m && n < 200);
        chk({tag, " latency"}, 1024'(n), 1024'(lat));
        chk({tag, " c"}, c_m, e);
        chk({tag, " c stable"}, 1024'(stable), 1024'(1));
        chk({tag, " busy cycles"}, 1024'(nb), 1024'(lat));
        chk({tag, " ready"}, 1024'(ready_m), 1024'(1));
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, 1024'(done_m), 1024'(0));
    endtask

    initial begin
        logic [817:0] big;
        logic [15:0] x, y;
        int n;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1;
            chk("rst busy", 1024'(busy_m), 1024'(0));
            chk("rst done", 1024'(done_m), 1024'(0));
            chk("rst c", c_m, 1024'(0));
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1;
            chk("rel ready", 1024'(ready_m), 1024'(1));
        end

        big = '1;
        big = '0 - (818'(1) << 410) + 818'(1);
        run(0, '1, '1, 1024'(big), 52, "max409");

        run(1, 409'(16'hFFFF), 409'(16'h1234), 1024'(32'h1233EDCC), 4, "ffff");
        run(2, 409'(3), 409'(10'h3FF), 1024'(14'hBFD), 3, "pad");
        run(3, 409'(8'hFF), 409'(8'hFF), 1024'(16'hFE01), 8, "bitser");
        run(1, 409'(0), 409'(16'h1234), 1024'(0), 4, "a0");
        run(3, 409'(8'hA5), 409'(0), 1024'(0), 8, "b0");

        for (int i = 0; i < 6; i++) begin
            x = 16'($urandom_range(0, 65535));
            y = 16'($urandom_range(0, 65535));
            run(1, 409'(x), 409'(y),
                1024'({16'b0, x} * {16'b0, y}), 4, "rnd");
        end

        sel = 1;
        @(negedge clk);
        av = 409'(5);
        bv = 409'(7);
        st[1] = 1'b1;
        @(posedge clk);
        #1;
        av = 409'(9);
        bv = 409'(9);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done_m && n < 50);
        chk("b2b lat", 1024'(n), 1024'(4));
        chk("b2b c1", c_m, 1024'(35));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done_m && n < 50);
        st[1] = 1'b0;
        chk("b2b gap", 1024'(n), 1024'(5));
        chk("b2b c2", c_m, 1024'(81));

        @(negedge clk);
        av = 409'(16'hFFFF);
        bv = 409'(16'h1234);
        st[1] = 1'b1;
        @(posedge clk);
        #1;
        st[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst c", c_m, 1024'(0));
        chk("arst done", 1024'(done_m), 1024'(0));
        chk("arst busy", 1024'(busy_m), 1024'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst ready", 1024'(ready_m), 1024'(1));
        run(1, 409'(6), 409'(7), 1024'(42), 4, "post rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
